// File: rtl/memblock_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : memblock_pkg
//  Purpose  : Shared types and helpers for the memblock_mp register file:
//             the clear-sequencer state enum, the byte-lane width and the
//             lane merge used by both the write path and read forwarding.
//  Revision : 1.0  initial release
// ============================================================================
package memblock_pkg;

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } mb_state_e;

    localparam int LANE_W = 8;

    // Selects the new lane value when its byte enable is set, else keeps old.
    function automatic logic [LANE_W-1:0] mb_lane_merge(
        input logic [LANE_W-1:0] old_lane,
        input logic [LANE_W-1:0] new_lane,
        input logic              be
    );
        return be ? new_lane : old_lane;
    endfunction

endpackage
`default_nettype wire

// File: rtl/memblock_clear_seq.sv
`default_nettype none
// ============================================================================
//  Module   : memblock_clear_seq
//  Purpose  : Clear sweep sequencer. After reset, or on a clr request while
//             idle, zeroes one array word per cycle from address 0 up to
//             DEPTH-1, then returns to idle.
//  Ports    : clk, rst (sync, active-low), i_clr (sweep request),
//             o_busy (reset or sweeping), o_wr_ok (array may accept writes),
//             clr_we / clr_addr (zero-write strobe and address to the array)
//  Revision : 1.0  initial release
// ============================================================================
module memblock_clear_seq #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    output logic          o_busy,
    output logic          o_wr_ok,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);
    import memblock_pkg::*;

    localparam logic [AW-1:0] C_LAST = AW'(DEPTH - 1);

    mb_state_e     state_q, state_d;
    logic [AW-1:0] ptr_q,   ptr_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // A clr seen during a sweep is deliberately ignored: no restart, no queue.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            S_CLEAR: begin
                if (ptr_q == C_LAST) begin
                    state_d = S_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + AW'(1);
                end
            end
            S_IDLE: begin
                if (i_clr) begin
                    state_d = S_CLEAR;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = S_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    assign o_busy   = (state_q == S_CLEAR) | ~rst;
    assign o_wr_ok  = (state_q == S_IDLE) & rst;
    assign clr_we   = (state_q == S_CLEAR) & rst;
    assign clr_addr = ptr_q;

endmodule
`default_nettype wire

// File: rtl/memblock_mp.sv
`default_nettype none
// ============================================================================
//  Module   : memblock_mp
//  Purpose  : Multi-read-port register file with per-byte write enables,
//             optional registered reads, optional write-to-read forwarding
//             and a sequential zero sweep in place of array reset.
//  Ports    : clk, rst (sync, active-low), clr (start clear sweep),
//             busy (reset or sweeping),
//             we0 / wr_addr0 / wr_din0 / wr_be0 (single write port),
//             rd_addr (NRD packed addresses), rd_dout (NRD packed data)
//  Revision : 1.0  initial release
// ============================================================================
module memblock_mp #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int NRD    = 2,
    parameter int RD_REG = 0,
    parameter int WR_FWD = 1,
    localparam int AW    = $clog2(DEPTH),
    localparam int NLANE = WIDTH / 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    output logic                 busy,
    input  logic                 we0,
    input  logic [AW-1:0]        wr_addr0,
    input  logic [WIDTH-1:0]     wr_din0,
    input  logic [NLANE-1:0]     wr_be0,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*WIDTH-1:0] rd_dout
);
    import memblock_pkg::*;

    // One extra bit so DEPTH itself is representable for range checks.
    localparam logic [AW:0] C_DEPTH = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             w_busy;
    logic             w_wr_ok;
    logic             w_clr_we;
    logic [AW-1:0]    w_clr_addr;
    logic             w_wr_acc;
    logic [WIDTH-1:0] w_wr_old;
    logic [WIDTH-1:0] w_wr_word;

    memblock_clear_seq #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (clr),
        .o_busy   (w_busy),
        .o_wr_ok  (w_wr_ok),
        .clr_we   (w_clr_we),
        .clr_addr (w_clr_addr)
    );

    assign busy     = w_busy;
    assign w_wr_acc = we0 & w_wr_ok & ({1'b0, wr_addr0} < C_DEPTH);

    // Read-modify-write of the addressed word; only used when accepted.
    always_comb begin
        w_wr_old  = mem_q[wr_addr0];
        w_wr_word = '0;
        for (int i = 0; i < NLANE; i++) begin
            w_wr_word[i*LANE_W +: LANE_W] = mb_lane_merge(
                w_wr_old[i*LANE_W +: LANE_W], wr_din0[i*LANE_W +: LANE_W], wr_be0[i]);
        end
    end

    // Sweep and user writes are mutually exclusive by construction.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            mem_q[w_clr_addr] <= '0;
        end else if (w_wr_acc) begin
            mem_q[wr_addr0] <= w_wr_word;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]    w_ra;
        logic             w_in_range;
        logic             w_hit;
        logic [WIDTH-1:0] w_stored;
        logic [WIDTH-1:0] rd_d;

        assign w_ra       = rd_addr[p*AW +: AW];
        assign w_in_range = ({1'b0, w_ra} < C_DEPTH);
        assign w_hit      = (WR_FWD != 0) && w_wr_acc && (w_ra == wr_addr0);

        // Contents are only meaningful once the sweep has finished, so any
        // read while busy is forced to zero.
        always_comb begin
            w_stored = w_in_range ? mem_q[w_ra] : '0;
            rd_d     = '0;
            for (int i = 0; i < NLANE; i++) begin
                rd_d[i*LANE_W +: LANE_W] = mb_lane_merge(
                    w_stored[i*LANE_W +: LANE_W], wr_din0[i*LANE_W +: LANE_W],
                    w_hit & wr_be0[i]);
            end
            if (w_busy) begin
                rd_d = '0;
            end
        end

        if (RD_REG != 0) begin : g_reg
            logic [WIDTH-1:0] rd_q;
            always_ff @(posedge clk) begin
                if (!rst) begin
                    rd_q <= '0;
                end else begin
                    rd_q <= rd_d;
                end
            end
            assign rd_dout[p*WIDTH +: WIDTH] = rd_q;
        end else begin : g_comb
            assign rd_dout[p*WIDTH +: WIDTH] = rd_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memblock_mp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_memblock_mp
//  Purpose  : Self-checking bench for memblock_mp. Two instances share one
//             stimulus stream: A (DEPTH=6, combinational read, forwarding)
//             and B (DEPTH=8, registered read, no forwarding). A behavioural
//             model (countdown sweep, word arrays) predicts every output.
//  Revision : 1.0  initial release
// ============================================================================
module tb_memblock_mp;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clr, we0;
    logic [2:0]  wr_addr0;
    logic [31:0] wr_din0;
    logic [3:0]  wr_be0;
    logic [5:0]  rd_addr;
    logic        busy_a, busy_b;
    logic [63:0] rd_a, rd_b;

    memblock_mp #(.WIDTH(32), .DEPTH(6), .NRD(2), .RD_REG(0), .WR_FWD(1)) u_a (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy_a), .we0(we0),
        .wr_addr0(wr_addr0), .wr_din0(wr_din0), .wr_be0(wr_be0),
        .rd_addr(rd_addr), .rd_dout(rd_a)
    );

    memblock_mp #(.WIDTH(32), .DEPTH(8), .NRD(2), .RD_REG(1), .WR_FWD(0)) u_b (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy_b), .we0(we0),
        .wr_addr0(wr_addr0), .wr_din0(wr_din0), .wr_be0(wr_be0),
        .rd_addr(rd_addr), .rd_dout(rd_b)
    );

    typedef struct {
        logic        we;
        logic [2:0]  addr;
        logic [31:0] din;
        logic [3:0]  be;
        logic [2:0]  r0;
        logic [2:0]  r1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    // Reference model: index 0 tracks instance A, index 1 instance B.
    int          depth [2] = '{6, 8};
    int          rem   [2];
    logic [31:0] mdl   [2][8];
    logic [31:0] exp_b_reg [2];
    logic        s_busy_a, s_busy_b;
    int          n_pass  = 0;
    int          n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] exp_rd(input int k, input logic [2:0] ra, input bit fwd);
        logic [31:0] w;
        if (!rst || rem[k] != 0 || int'(ra) >= depth[k]) return 32'h0;
        w = mdl[k][ra];
        if (fwd && we0 && wr_addr0 == ra) begin
            for (int l = 0; l < 4; l++)
                if (wr_be0[l]) w[8*l +: 8] = wr_din0[8*l +: 8];
        end
        return w;
    endfunction

    task automatic model_zero(input int k);
        for (int a = 0; a < 8; a++) mdl[k][a] = 32'h0;
    endtask

    task automatic model_edge(input int k);
        if (!rst) begin
            rem[k] = depth[k];
            model_zero(k);
        end else if (rem[k] != 0) begin
            rem[k]--;
        end else begin
            if (we0 && int'(wr_addr0) < depth[k]) begin
                for (int l = 0; l < 4; l++)
                    if (wr_be0[l]) mdl[k][wr_addr0][8*l +: 8] = wr_din0[8*l +: 8];
            end
            if (clr) begin
                rem[k] = depth[k];
                model_zero(k);
            end
        end
    endtask

    // Inputs are already applied; sample on the falling edge, then advance.
    task automatic cycle(input bit use_tbl, input logic [31:0] e0, input logic [31:0] e1);
        @(negedge clk);
        s_busy_a = busy_a;
        s_busy_b = busy_b;
        chk("busy_a", {31'b0, busy_a}, {31'b0, (!rst || rem[0] != 0)});
        chk("busy_b", {31'b0, busy_b}, {31'b0, (!rst || rem[1] != 0)});
        chk("rd_a_p0", rd_a[31:0],  exp_rd(0, rd_addr[2:0], 1'b1));
        chk("rd_a_p1", rd_a[63:32], exp_rd(0, rd_addr[5:3], 1'b1));
        chk("rd_b_p0", rd_b[31:0],  exp_b_reg[0]);
        chk("rd_b_p1", rd_b[63:32], exp_b_reg[1]);
        if (use_tbl) begin
            chk("vec_busy_a", {31'b0, busy_a}, 32'h0);
            chk("vec_rd_a_p0", rd_a[31:0],  e0);
            chk("vec_rd_a_p1", rd_a[63:32], e1);
        end
        exp_b_reg[0] = exp_rd(1, rd_addr[2:0], 1'b0);
        exp_b_reg[1] = exp_rd(1, rd_addr[5:3], 1'b0);
        model_edge(0);
        model_edge(1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t tbl [10];
        int   cnt_a, cnt_b;

        tbl[0] = '{1'b1, 3'd3, 32'hAABBCCDD, 4'hF, 3'd3, 3'd3, 32'hAABBCCDD, 32'hAABBCCDD};
        tbl[1] = '{1'b1, 3'd3, 32'h11223344, 4'h5, 3'd3, 3'd2, 32'hAA22CC44, 32'h00000000};
        tbl[2] = '{1'b0, 3'd0, 32'h00000000, 4'h0, 3'd3, 3'd7, 32'hAA22CC44, 32'h00000000};
        tbl[3] = '{1'b1, 3'd7, 32'h000000FF, 4'hF, 3'd7, 3'd3, 32'h00000000, 32'hAA22CC44};
        tbl[4] = '{1'b1, 3'd5, 32'hDEADBEEF, 4'hF, 3'd0, 3'd5, 32'h00000000, 32'hDEADBEEF};
        tbl[5] = '{1'b0, 3'd0, 32'h00000000, 4'h0, 3'd5, 3'd6, 32'hDEADBEEF, 32'h00000000};
        tbl[6] = '{1'b1, 3'd5, 32'h00000000, 4'h0, 3'd5, 3'd5, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[7] = '{1'b1, 3'd2, 32'h12345678, 4'hF, 3'd2, 3'd4, 32'h12345678, 32'h00000000};
        tbl[8] = '{1'b0, 3'd0, 32'h00000000, 4'h0, 3'd2, 3'd2, 32'h12345678, 32'h12345678};
        tbl[9] = '{1'b0, 3'd0, 32'h00000000, 4'h0, 3'd3, 3'd5, 32'hAA22CC44, 32'hDEADBEEF};

        rst = 1'b0; clr = 1'b0; we0 = 1'b0;
        wr_addr0 = '0; wr_din0 = '0; wr_be0 = '0; rd_addr = '0;
        for (int k = 0; k < 2; k++) begin
            rem[k] = depth[k];
            model_zero(k);
            exp_b_reg[k] = 32'h0;
        end
        @(posedge clk);
        #1;

        // Power-up: reset held three cycles, then the full sweep.
        repeat (3) cycle(1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 12; i++) begin
            rd_addr = 6'($urandom);
            cycle(1'b0, 32'h0, 32'h0);
            cnt_a += int'(s_busy_a);
            cnt_b += int'(s_busy_b);
        end
        chk("reset_sweep_len_a", 32'(cnt_a), 32'd6);
        chk("reset_sweep_len_b", 32'(cnt_b), 32'd8);

        // Directed vectors: byte enables, forwarding, out of range.
        for (int i = 0; i < 10; i++) begin
            we0      = tbl[i].we;
            wr_addr0 = tbl[i].addr;
            wr_din0  = tbl[i].din;
            wr_be0   = tbl[i].be;
            rd_addr  = {tbl[i].r1, tbl[i].r0};
            cycle(1'b1, tbl[i].e0, tbl[i].e1);
        end
        we0 = 1'b0;

        // Runtime clear: fill, one-cycle clr, writes attempted during sweep.
        for (int a = 0; a < 8; a++) begin
            we0 = 1'b1; wr_addr0 = 3'(a); wr_din0 = $urandom; wr_be0 = 4'hF;
            rd_addr = 6'($urandom);
            cycle(1'b0, 32'h0, 32'h0);
        end
        we0 = 1'b0; clr = 1'b1;
        cycle(1'b0, 32'h0, 32'h0);
        clr = 1'b0;
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 12; i++) begin
            we0 = (i < 5); wr_addr0 = 3'($urandom); wr_din0 = $urandom; wr_be0 = 4'hF;
            clr = (i == 2);
            rd_addr = 6'($urandom);
            cycle(1'b0, 32'h0, 32'h0);
            cnt_a += int'(s_busy_a);
            cnt_b += int'(s_busy_b);
        end
        clr = 1'b0; we0 = 1'b0;
        chk("clr_sweep_len_a", 32'(cnt_a), 32'd6);
        chk("clr_sweep_len_b", 32'(cnt_b), 32'd8);
        for (int a = 0; a < 8; a++) begin
            rd_addr = {3'(a), 3'(a)};
            cycle(1'b1, 32'h0, 32'h0);
        end

        // Reset on the fourth sweep cycle restarts a full-length sweep.
        clr = 1'b1;
        cycle(1'b0, 32'h0, 32'h0);
        clr = 1'b0;
        repeat (3) cycle(1'b0, 32'h0, 32'h0);
        rst = 1'b0;
        cycle(1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 12; i++) begin
            rd_addr = 6'($urandom);
            cycle(1'b0, 32'h0, 32'h0);
            cnt_a += int'(s_busy_a);
            cnt_b += int'(s_busy_b);
        end
        chk("restart_sweep_len_a", 32'(cnt_a), 32'd6);
        chk("restart_sweep_len_b", 32'(cnt_b), 32'd8);

        // Randomised traffic against the model.
        for (int i = 0; i < 800; i++) begin
            rst      = ($urandom_range(0, 99) != 0);
            clr      = ($urandom_range(0, 59) == 0);
            we0      = 1'($urandom);
            wr_addr0 = 3'($urandom);
            wr_din0  = $urandom;
            wr_be0   = 4'($urandom);
            rd_addr  = 6'($urandom);
            if ($urandom_range(0, 1) == 1) rd_addr[2:0] = wr_addr0;
            if ($urandom_range(0, 2) == 1) rd_addr[5:3] = wr_addr0;
            cycle(1'b0, 32'h0, 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memblock_mp.md
# memblock_mp

Parametrised multi-read-port successor to the single-port `Memblock` register file. It adds per-byte write enables, a configurable number of read ports, optional registered reads, write-to-read forwarding, and a sequential clear engine. The clear engine replaces whole-array reset fan-out with a one-address-per-cycle zero sweep. The block sits under the register-file and scratchpad wrappers wherever more than one read per cycle is needed.

## Interface
- `WIDTH`, 32 — data bits per word; must be a multiple of 8.
- `DEPTH`, 32 — number of words; ≥ 2; need not be a power of two.
- `NRD`, 2 — number of read ports, ≥ 1.
- `RD_REG`, 0 — 0: combinational read; 1: read data registered (1-cycle latency).
- `WR_FWD`, 1 — 1: a same-cycle write to the read address is forwarded to the read port; 0: the read returns old data.
- Derived: `AW = $clog2(DEPTH)`, `NLANE = WIDTH/8`.
- `clk  in  1` — single clock, rising edge.
- `rst  in  1` — synchronous, active-low reset.
- `clr  in  1` — request a runtime clear sweep; pulse or level.
- `busy  out  1` — high while in reset or while a clear sweep is running.
- `we0  in  1` — write enable.
- `wr_addr0  in  AW` — write address.
- `wr_din0  in  WIDTH` — write data.
- `wr_be0  in  NLANE` — byte-lane enables; bit i covers `wr_din0[8i+7:8i]`.
- `rd_addr  in  NRD*AW` — packed read addresses; port p is `[p*AW +: AW]`.
- `rd_dout  out  NRD*WIDTH` — packed read data; port p is `[p*WIDTH +: WIDTH]`.

## Operation
- **States:** `S_CLEAR`, `S_IDLE`.
- **Reset:** any rising edge with `rst=0` sets state to `S_CLEAR` and the clear pointer `ptr` to 0. No storage cell is reset directly.
- **S_CLEAR:** each rising edge with `rst=1` writes zero to `mem[ptr]` and increments `ptr`. On the edge that clears `ptr==DEPTH-1`, the state moves to `S_IDLE`.
- **busy:** equals `(state==S_CLEAR) | !rst`.
- **S_IDLE + clr=1:** at the edge, move to `S_CLEAR` with `ptr=0`. A `clr` that arrives during `S_CLEAR` is ignored; there is no restart and no queueing.
- **Writes:** when `we0=1`, state is `S_IDLE`, and `wr_addr0 < DEPTH`, each lane with `wr_be0[i]=1` is updated at the edge. Writes in `S_CLEAR`, out-of-range writes, and `wr_be0=0` are dropped silently.
- **Reads:** each port is independent, and any number of ports may read the same address. `rd_addr ≥ DEPTH` returns 0.
- **Reads during S_CLEAR or while rst=0:** return 0 on all ports, regardless of array contents.
- **Forwarding (`WR_FWD=1`):** if a read address equals `wr_addr0` and the write is accepted this cycle, lanes with `wr_be0=1` take `wr_din0`. The remaining lanes take stored data.
- **Reset mid-sweep:** restarts the sweep from 0.
- **Write plus clr in the same S_IDLE cycle:** the write is performed first, then the sweep starts on the next edge and overwrites it.

## Timing
- **RD_REG=0:** `rd_dout` is combinational from `rd_addr` and stored state (plus write inputs when `WR_FWD=1`). Latency is 0.
- **RD_REG=1:** `rd_dout` is registered, reset to 0, and valid on the edge after the address is presented. Forwarding applies to the write in the address cycle.
- **Sweep length:** `busy` stays high for exactly `DEPTH` edges after the first edge with `rst=1`. It is low from edge `DEPTH` onward.
- **Output reset values:** `busy=1` and `rd_dout=0`.
- **Read-after-write:** without forwarding, the new data is visible one cycle after the write (`RD_REG=0`) or two cycles after (`RD_REG=1`).

## Structure
- Package `memblock_pkg` holds:
  - the state enum `mb_state_e` (`S_CLEAR`, `S_IDLE`);
  - `LANE_W=8`;
  - a function `mb_lane_merge(old, new, be)` shared by the write path and forwarding.
- Sub-module `memblock_clear_seq` contains the FSM, `ptr`, and `busy`. It outputs `clr_we` and `clr_addr` to the array.
- Read ports are built in a `generate` loop over `NRD`.

## Test plan
- **Reset sweep:** `DEPTH=8`, `rst` low for 3 cycles then high → `busy` high for exactly 8 edges after release. All reads return 0 during and after the sweep.
- **Byte enables:** write `0xAABBCCDD` with `be=4'b1111` to address 3, then `0x11223344` with `be=4'b0101` → read of address 3 returns `0xAA22CC44`.
- **Forwarding:** `WR_FWD=1`, `RD_REG=0`, address 5 holds `0x0`; write `0xDEADBEEF` to address 5 while port 1 reads address 5 → `rd_dout` port 1 shows `0xDEADBEEF` in the same cycle. With `WR_FWD=0` → `0x0`, then `0xDEADBEEF` next cycle.
- **Registered read:** `RD_REG=1`, address 2 = `0x12345678`; present address 2 at cycle n → `rd_dout` = `0x12345678` at cycle n+1 and 0 at cycle n.
- **Runtime clear:** fill all addresses, assert `clr` for 1 cycle → `busy` high for `DEPTH` cycles and writes during the sweep are dropped; afterwards all addresses read 0. Assert `rst` at sweep cycle 4 → the sweep restarts for a full `DEPTH` cycles.
- **Out of range:** `DEPTH=6`, write `0xFF` to address 7 → no cell changes, and a read of address 7 returns 0.
